// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit arbiter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  localparam int UART_DATA_W = 8;
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible at or after the pointer.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    int j;
    j = 0;
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_any && i_elig[j]) begin
        o_grant[j] = 1'b1;
        o_idx = IW'(j);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte producers,
// with per-requester message locking and a busy-handshake timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BUSY_TMO = 4,
  localparam int OW = owner_w(N_REQ),
  localparam int CW = $clog2(BUSY_TMO + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     tx_busy,
  output logic                     tx_wr_enb,
  output logic [UART_DATA_W-1:0]   tx_data,
  output logic [OW-1:0]            owner,
  output logic                     locked,
  output logic                     err_tmo
);
  state_t                 r_state;
  logic [OW-1:0]          r_ptr, r_owner, w_idx;
  logic [CW-1:0]          r_cnt;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_locked, r_err, r_wr, w_any;
  logic [N_REQ-1:0]       w_elig, w_grant;
  assign w_elig = r_locked ? req_valid & (N_REQ'(1) << r_owner) : req_valid;
  rr_pick #(.N(N_REQ), .IW(OW)) u_pick (
    .i_elig(w_elig), .i_ptr(r_ptr), .o_grant(w_grant), .o_idx(w_idx), .o_any(w_any)
  );
  assign req_ready = (reset_n && r_state == IDLE) ? w_grant : '0;
  assign tx_wr_enb = r_wr;
  assign tx_data   = r_data;
  assign owner     = r_owner;
  assign locked    = r_locked;
  assign err_tmo   = r_err;
  // busy may rise as late as BUSY_TMO cycles after the write pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_data   <= req_data[{w_idx, 3'b000} +: UART_DATA_W];
          r_owner  <= w_idx;
          r_locked <= ~req_last[w_idx];
          r_wr     <= 1'b1;
          r_state  <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (tx_busy) r_state <= WAIT_DONE;
          else if (r_cnt == CW'(BUSY_TMO - 1)) begin
            r_err    <= 1'b1;
            r_locked <= 1'b0;
            r_state  <= IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        WAIT_DONE: if (!tx_busy) begin
          r_state <= IDLE;
          if (!r_locked) r_ptr <= (r_owner == OW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks against a queue-based arbitration model
// that also plays the transmitter's busy handshake.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TMO = 4;
  typedef struct packed {logic [7:0] d; logic l; logic [7:0] g;} item_t;
  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_busy = 1'b0;
  logic           tx_wr_enb;
  logic [7:0]     tx_data;
  logic [1:0]     owner;
  logic           locked;
  logic           err_tmo;
  item_t q[N][$];
  int    gap[N];
  int    pop_pending = -1;
  int    m_ptr = 0, m_owner = 0;
  bit    m_locked = 0, m_err = 0;
  int    total = 0, bad = 0;
  uart_tx_arbiter #(.N_REQ(N), .BUSY_TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_busy(tx_busy), .tx_wr_enb(tx_wr_enb),
    .tx_data(tx_data), .owner(owner), .locked(locked), .err_tmo(err_tmo)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int i, input logic [7:0] d, input logic l, input logic [7:0] g);
    q[i].push_back({d, l, g});
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (q[i].size() > 0) && (gap[i] == 0);
      req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0].d : 8'h00;
      req_last[i] = (q[i].size() > 0) ? q[i][0].l : 1'b0;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
    if (pop_pending >= 0) begin
      gap[pop_pending] = int'(q[pop_pending][0].g);
      void'(q[pop_pending].pop_front());
      pop_pending = -1;
    end
    drive();
    #1;
  endtask
  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j] && (!m_locked || j == m_owner)) return j;
    end
    return -1;
  endfunction
  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
    return 1;
  endfunction
  // One IDLE-cycle decision, plus the full frame when a grant is expected.
  task automatic serve_one();
    int g, lat, len;
    logic [7:0] d;
    g = exp_grant();
    chk("idle_wr", tx_wr_enb, 0);
    if (g < 0) begin
      chk("no_grant", req_ready, 0);
      step();
      return;
    end
    chk("grant", req_ready, 32'(1) << g);
    d = q[g][0].d;
    m_owner = g;
    m_locked = !q[g][0].l;
    pop_pending = g;
    step();
    chk("issue_wr", tx_wr_enb, 1);
    chk("issue_data", tx_data, d);
    chk("issue_owner", owner, m_owner);
    chk("issue_locked", locked, m_locked);
    chk("issue_err", err_tmo, m_err);
    chk("issue_ready", req_ready, 0);
    lat = $urandom_range(1, TMO);
    len = $urandom_range(1, 6);
    for (int k = 1; k <= lat + len; k++) begin
      step();
      tx_busy = (k >= lat) && (k < lat + len);
      chk("frame_wr", tx_wr_enb, 0);
      chk("frame_data", tx_data, d);
      chk("frame_ready", req_ready, 0);
    end
    if (!m_locked) m_ptr = (m_owner + 1) % N;
    step();
  endtask
  task automatic serve_all();
    int guard;
    guard = 0;
    while (!queues_empty() && guard < 3000) begin
      serve_one();
      guard++;
    end
    chk("drain", queues_empty(), 1);
  endtask
  initial begin
    for (int i = 0; i < N; i++) gap[i] = 0;
    step();
    step();
    chk("rst_wr", tx_wr_enb, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_tmo, 0);
    chk("rst_data", tx_data, 0);
    reset_n = 1'b1;
    step();
    push(0, 8'hA5, 1, 0);
    drive();
    #1;
    serve_all();
    chk("single_owner", owner, 0);
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1, 0);
    drive();
    #1;
    serve_all();
    push(2, 8'h41, 0, 0);
    push(2, 8'h42, 0, 0);
    push(2, 8'h43, 1, 0);
    push(0, 8'h50, 1, 0);
    push(3, 8'h53, 1, 0);
    drive();
    #1;
    serve_all();
    push(1, 8'h61, 0, 50);
    push(1, 8'h62, 1, 0);
    push(0, 8'h60, 1, 0);
    push(0, 8'h6F, 1, 0);
    drive();
    #1;
    serve_all();
    push(1, 8'h77, 0, 0);
    drive();
    #1;
    chk("tmo_grant", req_ready, 32'(1) << exp_grant());
    m_owner = 1;
    m_locked = 1;
    pop_pending = 1;
    step();
    chk("tmo_wr", tx_wr_enb, 1);
    chk("tmo_locked", locked, 1);
    for (int k = 1; k <= TMO; k++) begin
      step();
      tx_busy = 1'b0;
      chk("tmo_err_early", err_tmo, 0);
      chk("tmo_wr_low", tx_wr_enb, 0);
    end
    step();
    m_err = 1;
    m_locked = 0;
    chk("tmo_err", err_tmo, 1);
    chk("tmo_unlock", locked, 0);
    push(3, 8'h33, 1, 0);
    drive();
    #1;
    serve_all();
    push(2, 8'h21, 0, 0);
    push(2, 8'h22, 1, 0);
    drive();
    #1;
    chk("mid_grant", req_ready, 32'(1) << exp_grant());
    pop_pending = 2;
    step();
    chk("mid_wr", tx_wr_enb, 1);
    chk("mid_locked", locked, 1);
    tx_busy = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr", tx_wr_enb, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_err", err_tmo, 0);
    chk("mid_rst_data", tx_data, 0);
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      gap[i] = 0;
    end
    tx_busy = 1'b0;
    m_ptr = 0;
    m_owner = 0;
    m_locked = 0;
    m_err = 0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_wr", tx_wr_enb, 0);
    push(2, 8'h2A, 1, 0);
    push(0, 8'h0A, 1, 0);
    drive();
    #1;
    chk("post_rst_first", req_ready, 1);
    serve_all();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          int nb;
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++)
            push(i, 8'($urandom), b == nb - 1, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 6)) : 8'd0);
        end
      end
      drive();
      #1;
      serve_all();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART `transmitter` between `N_REQ` byte producers. Round-robin arbitration picks a requester, latches its byte, pulses the transmitter's `wr_enb`, and tracks `busy` through the whole frame before granting again. An optional per-requester lock (`req_last`) keeps multi-byte messages contiguous on the line. Sits directly in front of `transmitter`; its `tx_*` outputs wire straight to `wr_enb`/`data_in`, and `busy` feeds back.

## Interface
- `N_REQ`, default 4: number of requesters, ≥1.
- `BUSY_TMO`, default 4: cycles allowed from `wr_enb` pulse to `busy` high before error.
- `clk` in 1: single clock, shared with `transmitter`.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: requester i has a byte pending; must hold with data stable until `req_ready[i]`.
- `req_data` in 8*N_REQ: byte i at bits [8i+7:8i].
- `req_last` in N_REQ: byte i ends its message; 0 locks the channel to requester i.
- `req_ready` out N_REQ: one-hot accept, combinational, high for one cycle.
- `tx_busy` in 1: transmitter `busy`.
- `tx_wr_enb` out 1: one-cycle write pulse to the transmitter.
- `tx_data` out 8: held byte; stable from the pulse until the frame ends.
- `owner` out max(1,clog2(N_REQ)): current or last granted requester.
- `locked` out 1: channel reserved for `owner`.
- `err_tmo` out 1: sticky, set when `busy` never rose; cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: eligible set = `req_valid` masked to `owner` only if `locked`, else all. If nonempty:
  - grant g = first eligible at or after `rr_ptr`, wrapping.
  - `req_ready[g]`=1 this cycle.
  - latch `req_data[g]` into `tx_data`, g into `owner`.
  - `locked` ← ~`req_last[g]`; go to ISSUE.
- ISSUE: `tx_wr_enb`=1 for exactly this cycle; clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_busy`=1 → WAIT_DONE.
  - otherwise count; at count=`BUSY_TMO` set `err_tmo`, clear `locked`, go to IDLE.
- WAIT_DONE: `tx_busy`=0 → IDLE. If not `locked`, `rr_ptr` ← (`owner`+1) mod N_REQ. Else `rr_ptr` unchanged.
- Locked requester with no valid byte: channel stays idle. Other requesters are never granted until a `req_last`=1 byte from `owner` is accepted.
- `tx_wr_enb` never asserts outside ISSUE. There is never a second pulse before `busy` has fallen.
- Reset (any state, mid-frame included):
  - state=IDLE, `rr_ptr`=0, `owner`=0.
  - `locked`=0, `err_tmo`=0, `tx_data`=0.
  - `tx_wr_enb`=0, `req_ready`=0.
  - No byte is replayed.

## Timing
- Accept at cycle T (IDLE) → `tx_wr_enb` at T+1 → `tx_busy` seen high at T+2 → WAIT_DONE.
- Frame end: first cycle `tx_busy`=0 in WAIT_DONE → IDLE next cycle. Earliest next accept is that IDLE cycle, so a 1-cycle turnaround after `busy` falls.
- `req_ready` depends combinationally on `req_valid`. No other combinational input→output paths.
- `req_valid` rising in the same cycle the FSM enters IDLE is eligible that cycle.
- N_REQ=1: pointer constant 0; lock still honoured.

## Structure
- Shared package `uart_pkg`:
  - state enum {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE}.
  - `UART_DATA_W`=8.
  - owner-width helper function.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs: eligible vector, pointer. Outputs: one-hot grant, index, any.
- Pointer/lock registers and the FSM stay in `uart_tx_arbiter`.

## Test plan
- Single requester: `req_valid[0]`, data 0xA5, last=1 → `req_ready[0]` at T, one `tx_wr_enb` at T+1 with `tx_data`=0xA5. Serial line shows 0xA5 LSB-first; `owner`=0; no second pulse.
- All four valid, last=1, bytes 0x10..0x13 → grants in order 0,1,2,3,0… with exactly one frame each. `rr_ptr` advances after every frame.
- Requester 2 sends 0x41,0x42 (last=0) then 0x43 (last=1) while 0 and 3 stay valid → three consecutive frames from 2, `locked` high until the 0x43 accept, then requester 3 is granted.
- Lock hold: requester 1 sends last=0 then drops valid for 50 cycles while 0 is valid → no grant to 0, `tx_wr_enb` stays 0. Requester 1 resumes → accepted immediately.
- Timeout: tie `tx_busy`=0 → `err_tmo` set BUSY_TMO cycles after the pulse, FSM returns to IDLE, next request still serviced.
- Reset mid-frame: assert `reset_n`=0 during WAIT_DONE with requester 2 locked → all outputs at reset values next cycle. After release, requester 0 is granted first.
